// File: rtl/pipe_pkg.sv
// Shared definitions for the CPU inter-stage pipeline registers: bundle widths,
// bubble control words, control-field bit positions and stage occupancy states.
package pipe_pkg;

  localparam int IFID_DATA_W  = 64;
  localparam int IFID_CTRL_W  = 1;
  localparam int IDEX_DATA_W  = 192;
  localparam int IDEX_CTRL_W  = 11;
  localparam int EXMEM_DATA_W = 101;
  localparam int EXMEM_CTRL_W = 5;
  localparam int MEMWB_DATA_W = 69;
  localparam int MEMWB_CTRL_W = 2;

  localparam logic [IFID_CTRL_W-1:0]  IFID_BUBBLE  = '0;
  localparam logic [IDEX_CTRL_W-1:0]  IDEX_BUBBLE  = '0;
  localparam logic [EXMEM_CTRL_W-1:0] EXMEM_BUBBLE = '0;
  localparam logic [MEMWB_CTRL_W-1:0] MEMWB_BUBBLE = '0;

  localparam int CTRL_MEMWRITE  = 10;
  localparam int CTRL_MEMREAD   = 9;
  localparam int CTRL_MEMTOREG  = 8;
  localparam int CTRL_ALUSRC    = 7;
  localparam int CTRL_REGWRITE  = 6;
  localparam int CTRL_BRANCH    = 5;
  localparam int CTRL_ALUCTL_LSB = 0;
  localparam int CTRL_ALUCTL_W  = 5;

  typedef struct packed {
    logic       mem_write;
    logic       mem_read;
    logic       mem_to_reg;
    logic       alu_src;
    logic       reg_write;
    logic       branch;
    logic [4:0] alu_control;
  } idex_ctrl_t;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } occ_e;

  function automatic logic [IDEX_CTRL_W-1:0] pack_idex_ctrl(input idex_ctrl_t c);
    logic [IDEX_CTRL_W-1:0] w;
    w = '0;
    w[CTRL_MEMWRITE] = c.mem_write;
    w[CTRL_MEMREAD]  = c.mem_read;
    w[CTRL_MEMTOREG] = c.mem_to_reg;
    w[CTRL_ALUSRC]   = c.alu_src;
    w[CTRL_REGWRITE] = c.reg_write;
    w[CTRL_BRANCH]   = c.branch;
    w[CTRL_ALUCTL_LSB +: CTRL_ALUCTL_W] = c.alu_control;
    return w;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter; holds at all-ones instead of wrapping.
module sat_counter
  import pipe_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] cnt
);

  function automatic logic [W-1:0] sat_inc(input logic [W-1:0] v);
    return (&v) ? v : v + W'(1);
  endfunction

  always_ff @(posedge clk) begin
    if (reset)    cnt <= '0;
    else if (inc) cnt <= sat_inc(cnt);
  end

endmodule

// File: rtl/pipe_stage_hs.sv
// Handshaked inter-stage pipeline register with optional 2-entry skid buffer,
// flush-to-bubble and a saturating back-pressure cycle counter.
module pipe_stage_hs
  import pipe_pkg::*;
#(
  parameter int                 DATA_W        = 192,
  parameter int                 CTRL_W        = 11,
  parameter logic [CTRL_W-1:0]  BUBBLE_CTRL   = '0,
  parameter int                 SKID          = 1,
  parameter int                 ZERO_ON_FLUSH = 1,
  parameter int                 CNT_W         = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt
);

  occ_e              state_p1, state_n;
  logic [DATA_W-1:0] head_data_p1;
  logic [CTRL_W-1:0] head_ctrl_p1;
  logic              in_xfer, out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  always_ff @(posedge clk) begin
    if (reset) state_p1 <= ST_EMPTY;
    else       state_p1 <= state_n;
  end

  always_comb begin
    out_valid = (state_p1 != ST_EMPTY);
    occupancy = state_p1;
    out_data  = head_data_p1;
    out_ctrl  = head_ctrl_p1;
  end

  generate
    if (SKID != 0) begin : g_skid
      logic [DATA_W-1:0] skid_data_p1;
      logic [CTRL_W-1:0] skid_ctrl_p1;

      assign in_ready = (state_p1 != ST_FULL);

      always_comb begin
        state_n = state_p1;
        case (state_p1)
          ST_EMPTY: if (in_xfer) state_n = ST_ONE;
          ST_ONE: begin
            if (in_xfer && !out_xfer)      state_n = ST_FULL;
            else if (!in_xfer && out_xfer) state_n = ST_EMPTY;
          end
          ST_FULL:  if (out_xfer) state_n = ST_ONE;
          default:  state_n = ST_EMPTY;
        endcase
        if (flush) state_n = ST_EMPTY;
      end

      // head/skid storage; head always carries the oldest entry
      always_ff @(posedge clk) begin
        if (reset) begin
          head_data_p1 <= '0;
          head_ctrl_p1 <= BUBBLE_CTRL;
          skid_data_p1 <= '0;
          skid_ctrl_p1 <= '0;
        end else if (flush) begin
          head_ctrl_p1 <= BUBBLE_CTRL;
          skid_ctrl_p1 <= '0;
          if (ZERO_ON_FLUSH != 0) begin
            head_data_p1 <= '0;
            skid_data_p1 <= '0;
          end
        end else begin
          case (state_p1)
            ST_EMPTY: if (in_xfer) begin
              head_data_p1 <= in_data;
              head_ctrl_p1 <= in_ctrl;
            end
            ST_ONE: begin
              if (in_xfer && out_xfer) begin
                head_data_p1 <= in_data;
                head_ctrl_p1 <= in_ctrl;
              end else if (in_xfer) begin
                skid_data_p1 <= in_data;
                skid_ctrl_p1 <= in_ctrl;
              end else if (out_xfer) begin
                head_ctrl_p1 <= BUBBLE_CTRL;
              end
            end
            ST_FULL: if (out_xfer) begin
              head_data_p1 <= skid_data_p1;
              head_ctrl_p1 <= skid_ctrl_p1;
              skid_data_p1 <= '0;
              skid_ctrl_p1 <= '0;
            end
            default: ;
          endcase
        end
      end
    end else begin : g_noskid
      assign in_ready = ~out_valid | out_ready;

      always_comb begin
        state_n = state_p1;
        if (in_xfer)       state_n = ST_ONE;
        else if (out_xfer) state_n = ST_EMPTY;
        if (flush)         state_n = ST_EMPTY;
      end

      // single head register; refilled in the same cycle it drains
      always_ff @(posedge clk) begin
        if (reset) begin
          head_data_p1 <= '0;
          head_ctrl_p1 <= BUBBLE_CTRL;
        end else if (flush) begin
          head_ctrl_p1 <= BUBBLE_CTRL;
          if (ZERO_ON_FLUSH != 0) head_data_p1 <= '0;
        end else if (in_xfer) begin
          head_data_p1 <= in_data;
          head_ctrl_p1 <= in_ctrl;
        end else if (out_xfer) begin
          head_ctrl_p1 <= BUBBLE_CTRL;
        end
      end
    end
  endgenerate

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (out_valid & ~out_ready),
    .cnt   (stall_cnt)
  );

endmodule

// File: tb/tb_pipe_stage_hs.sv
// Table-driven bench for pipe_stage_hs across three configurations:
// u_a skid/zero-on-flush/4-bit counter, u_b skid/hold-on-flush, u_c no skid.
module tb_pipe_stage_hs;
  import pipe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                   rst_a = 1, fl_a = 0, iv_a = 0, ordy_a = 0;
  logic [IDEX_DATA_W-1:0] id_a = '0, od_a;
  logic [10:0]            ic_a = '0, oc_a;
  logic                   irdy_a, ov_a;
  logic [1:0]             occ_a;
  logic [3:0]             cnt_a;

  logic        rst_b = 1, fl_b = 0, iv_b = 0, ordy_b = 0, irdy_b, ov_b;
  logic [31:0] id_b = '0, od_b;
  logic [10:0] ic_b = '0, oc_b;
  logic [1:0]  occ_b;
  logic [15:0] cnt_b;

  logic        rst_c = 1, fl_c = 0, iv_c = 0, ordy_c = 0, irdy_c, ov_c;
  logic [31:0] id_c = '0, od_c;
  logic [10:0] ic_c = '0, oc_c;
  logic [1:0]  occ_c;
  logic [15:0] cnt_c;

  pipe_stage_hs #(.DATA_W(IDEX_DATA_W), .CTRL_W(IDEX_CTRL_W), .BUBBLE_CTRL(IDEX_BUBBLE),
                  .SKID(1), .ZERO_ON_FLUSH(1), .CNT_W(4)) u_a (
    .clk(clk), .reset(rst_a), .flush(fl_a), .in_valid(iv_a), .in_ready(irdy_a),
    .in_data(id_a), .in_ctrl(ic_a), .out_valid(ov_a), .out_ready(ordy_a),
    .out_data(od_a), .out_ctrl(oc_a), .occupancy(occ_a), .stall_cnt(cnt_a));

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(11), .BUBBLE_CTRL(11'h2A5),
                  .SKID(1), .ZERO_ON_FLUSH(0), .CNT_W(16)) u_b (
    .clk(clk), .reset(rst_b), .flush(fl_b), .in_valid(iv_b), .in_ready(irdy_b),
    .in_data(id_b), .in_ctrl(ic_b), .out_valid(ov_b), .out_ready(ordy_b),
    .out_data(od_b), .out_ctrl(oc_b), .occupancy(occ_b), .stall_cnt(cnt_b));

  pipe_stage_hs #(.DATA_W(32), .CTRL_W(11), .BUBBLE_CTRL(11'h0F0),
                  .SKID(0), .ZERO_ON_FLUSH(1), .CNT_W(16)) u_c (
    .clk(clk), .reset(rst_c), .flush(fl_c), .in_valid(iv_c), .in_ready(irdy_c),
    .in_data(id_c), .in_ctrl(ic_c), .out_valid(ov_c), .out_ready(ordy_c),
    .out_data(od_c), .out_ctrl(oc_c), .occupancy(occ_c), .stall_cnt(cnt_c));

  typedef struct {
    int          which;
    logic        rst, fl, iv;
    logic [7:0]  itag;
    logic [10:0] ictrl;
    logic        ordy;
    logic        ov;
    logic [7:0]  otag;
    logic [10:0] octrl;
    logic        irdy;
    logic [1:0]  occ;
    logic [15:0] stall;
  } vec_t;

  vec_t vq[$];
  int applied = 0;
  int miscompares = 0;

  function automatic vec_t mk(input int w, input logic rst, fl, iv, input logic [7:0] it,
                              input logic [10:0] ic, input logic ordy, input logic ov,
                              input logic [7:0] ot, input logic [10:0] oc, input logic irdy,
                              input logic [1:0] occ, input logic [15:0] st);
    vec_t v;
    v.which = w; v.rst = rst; v.fl = fl; v.iv = iv; v.itag = it; v.ictrl = ic;
    v.ordy = ordy; v.ov = ov; v.otag = ot; v.octrl = oc; v.irdy = irdy;
    v.occ = occ; v.stall = st;
    return v;
  endfunction

  task automatic chk(input int idx, input string nm, input logic [191:0] act, exp);
    if (act !== exp) begin
      miscompares++;
      $display("FAIL vec %0d %s: got %0h expected %0h", idx, nm, act, exp);
    end
  endtask

  task automatic apply(input int idx, input vec_t v);
    logic [191:0] ad, ed;
    logic [10:0]  ac;
    logic [15:0]  as;
    logic [1:0]   ao;
    logic         av, ar;
    @(negedge clk);
    case (v.which)
      0: begin rst_a = v.rst; fl_a = v.fl; iv_a = v.iv; id_a = {24{v.itag}}; ic_a = v.ictrl; ordy_a = v.ordy; end
      1: begin rst_b = v.rst; fl_b = v.fl; iv_b = v.iv; id_b = {4{v.itag}}; ic_b = v.ictrl; ordy_b = v.ordy; end
      default: begin rst_c = v.rst; fl_c = v.fl; iv_c = v.iv; id_c = {4{v.itag}}; ic_c = v.ictrl; ordy_c = v.ordy; end
    endcase
    @(posedge clk);
    #1;
    case (v.which)
      0: begin av = ov_a; ad = od_a; ac = oc_a; ar = irdy_a; ao = occ_a; as = {12'b0, cnt_a}; end
      1: begin av = ov_b; ad = {160'b0, od_b}; ac = oc_b; ar = irdy_b; ao = occ_b; as = cnt_b; end
      default: begin av = ov_c; ad = {160'b0, od_c}; ac = oc_c; ar = irdy_c; ao = occ_c; as = cnt_c; end
    endcase
    ed = (v.which == 0) ? {24{v.otag}} : {160'b0, {4{v.otag}}};
    applied++;
    chk(idx, "out_valid", {191'b0, av}, {191'b0, v.ov});
    chk(idx, "out_data", ad, ed);
    chk(idx, "out_ctrl", {181'b0, ac}, {181'b0, v.octrl});
    chk(idx, "in_ready", {191'b0, ar}, {191'b0, v.irdy});
    chk(idx, "occupancy", {190'b0, ao}, {190'b0, v.occ});
    chk(idx, "stall_cnt", {176'b0, as}, {176'b0, v.stall});
  endtask

  initial begin
    logic [7:0] t;
    // u_a: reset, basic pass-through at full rate
    vq.push_back(mk(0, 1,0,0, 8'h00,11'h000, 0, 0,8'h00,11'h000, 1,2'd0, 16'd0));
    for (int k = 0; k < 8; k++) begin
      t = 8'hA5 + 8'(k);
      vq.push_back(mk(0, 0,0,1, t,11'h7FF, 1, 1,t,11'h7FF, 1,2'd1, 16'd0));
    end
    vq.push_back(mk(0, 0,0,0, 8'h00,11'h000, 1, 0,8'hAC,11'h000, 1,2'd0, 16'd0));
    // u_a: back-pressure fills skid, then drains in order
    vq.push_back(mk(0, 0,0,1, 8'h10,11'h011, 0, 1,8'h10,11'h011, 1,2'd1, 16'd0));
    vq.push_back(mk(0, 0,0,1, 8'h11,11'h012, 0, 1,8'h10,11'h011, 0,2'd2, 16'd1));
    vq.push_back(mk(0, 0,0,1, 8'h12,11'h013, 0, 1,8'h10,11'h011, 0,2'd2, 16'd2));
    vq.push_back(mk(0, 0,0,1, 8'h12,11'h013, 0, 1,8'h10,11'h011, 0,2'd2, 16'd3));
    vq.push_back(mk(0, 0,0,1, 8'h12,11'h013, 1, 1,8'h11,11'h012, 1,2'd1, 16'd3));
    vq.push_back(mk(0, 0,0,1, 8'h12,11'h013, 1, 1,8'h12,11'h013, 1,2'd1, 16'd3));
    vq.push_back(mk(0, 0,0,0, 8'h00,11'h000, 1, 0,8'h12,11'h000, 1,2'd0, 16'd3));
    // u_a: flush from FULL, flush with discarded in_xfer, flush with out_xfer
    vq.push_back(mk(0, 0,0,1, 8'h20,11'h021, 0, 1,8'h20,11'h021, 1,2'd1, 16'd3));
    vq.push_back(mk(0, 0,0,1, 8'h21,11'h022, 0, 1,8'h20,11'h021, 0,2'd2, 16'd4));
    vq.push_back(mk(0, 0,1,1, 8'h22,11'h023, 0, 0,8'h00,11'h000, 1,2'd0, 16'd5));
    vq.push_back(mk(0, 0,1,1, 8'h23,11'h024, 0, 0,8'h00,11'h000, 1,2'd0, 16'd5));
    vq.push_back(mk(0, 0,0,0, 8'h00,11'h000, 1, 0,8'h00,11'h000, 1,2'd0, 16'd5));
    vq.push_back(mk(0, 0,0,1, 8'h30,11'h031, 0, 1,8'h30,11'h031, 1,2'd1, 16'd5));
    vq.push_back(mk(0, 0,1,1, 8'h31,11'h032, 0, 0,8'h00,11'h000, 1,2'd0, 16'd6));
    vq.push_back(mk(0, 0,0,1, 8'h32,11'h033, 1, 1,8'h32,11'h033, 1,2'd1, 16'd6));
    vq.push_back(mk(0, 0,1,1, 8'h33,11'h034, 1, 0,8'h00,11'h000, 1,2'd0, 16'd6));
    // u_a: 4-bit counter saturates at 15, survives flush, cleared by reset
    vq.push_back(mk(0, 0,0,1, 8'h40,11'h041, 0, 1,8'h40,11'h041, 1,2'd1, 16'd6));
    for (int k = 1; k <= 20; k++)
      vq.push_back(mk(0, 0,0,0, 8'h00,11'h000, 0, 1,8'h40,11'h041, 1,2'd1,
                      16'((6 + k > 15) ? 15 : 6 + k)));
    vq.push_back(mk(0, 0,1,0, 8'h00,11'h000, 0, 0,8'h00,11'h000, 1,2'd0, 16'd15));
    vq.push_back(mk(0, 0,0,1, 8'h50,11'h051, 0, 1,8'h50,11'h051, 1,2'd1, 16'd15));
    vq.push_back(mk(0, 0,0,1, 8'h51,11'h052, 0, 1,8'h50,11'h051, 0,2'd2, 16'd15));
    vq.push_back(mk(0, 1,1,1, 8'h52,11'h053, 0, 0,8'h00,11'h000, 1,2'd0, 16'd0));
    vq.push_back(mk(0, 0,0,0, 8'h00,11'h000, 0, 0,8'h00,11'h000, 1,2'd0, 16'd0));
    // u_b: flush holds data, clears skid; reset still zeroes data
    vq.push_back(mk(1, 1,0,0, 8'h00,11'h000, 0, 0,8'h00,11'h2A5, 1,2'd0, 16'd0));
    vq.push_back(mk(1, 0,0,1, 8'h70,11'h071, 0, 1,8'h70,11'h071, 1,2'd1, 16'd0));
    vq.push_back(mk(1, 0,0,1, 8'h71,11'h072, 0, 1,8'h70,11'h071, 0,2'd2, 16'd1));
    vq.push_back(mk(1, 0,1,1, 8'h72,11'h073, 0, 0,8'h70,11'h2A5, 1,2'd0, 16'd2));
    vq.push_back(mk(1, 0,0,1, 8'h73,11'h074, 1, 1,8'h73,11'h074, 1,2'd1, 16'd2));
    vq.push_back(mk(1, 0,0,0, 8'h00,11'h000, 1, 0,8'h73,11'h2A5, 1,2'd0, 16'd2));
    vq.push_back(mk(1, 0,0,1, 8'h74,11'h075, 0, 1,8'h74,11'h075, 1,2'd1, 16'd2));
    vq.push_back(mk(1, 1,0,0, 8'h00,11'h000, 0, 0,8'h00,11'h2A5, 1,2'd0, 16'd0));
    vq.push_back(mk(1, 0,0,1, 8'h75,11'h076, 0, 1,8'h75,11'h076, 1,2'd1, 16'd0));
    vq.push_back(mk(1, 0,1,1, 8'h76,11'h077, 0, 0,8'h75,11'h2A5, 1,2'd0, 16'd1));
    vq.push_back(mk(1, 0,0,0, 8'h00,11'h000, 1, 0,8'h75,11'h2A5, 1,2'd0, 16'd1));
    // u_c: combinational ready follows out_ready, full-rate stream, flush
    vq.push_back(mk(2, 1,0,0, 8'h00,11'h000, 0, 0,8'h00,11'h0F0, 1,2'd0, 16'd0));
    vq.push_back(mk(2, 0,0,1, 8'h61,11'h061, 0, 1,8'h61,11'h061, 0,2'd1, 16'd0));
    vq.push_back(mk(2, 0,0,1, 8'h62,11'h062, 1, 1,8'h62,11'h062, 1,2'd1, 16'd0));
    vq.push_back(mk(2, 0,0,1, 8'h63,11'h063, 0, 1,8'h62,11'h062, 0,2'd1, 16'd1));
    vq.push_back(mk(2, 0,0,1, 8'h63,11'h063, 1, 1,8'h63,11'h063, 1,2'd1, 16'd1));
    vq.push_back(mk(2, 0,0,0, 8'h00,11'h000, 1, 0,8'h63,11'h0F0, 1,2'd0, 16'd1));
    for (int k = 0; k < 6; k++) begin
      t = 8'h80 + 8'(k);
      vq.push_back(mk(2, 0,0,1, t,{3'b0,t}, 1, 1,t,{3'b0,t}, 1,2'd1, 16'd1));
    end
    vq.push_back(mk(2, 0,0,0, 8'h00,11'h000, 1, 0,8'h85,11'h0F0, 1,2'd0, 16'd1));
    vq.push_back(mk(2, 0,0,1, 8'h64,11'h064, 0, 1,8'h64,11'h064, 0,2'd1, 16'd1));
    vq.push_back(mk(2, 0,1,1, 8'h65,11'h065, 1, 0,8'h00,11'h0F0, 1,2'd0, 16'd1));

    for (int i = 0; i < vq.size(); i++) apply(i, vq[i]);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule
